// File: rtl/debouncer_multi.sv
// Multi-channel input debouncer. Each channel has its own synchroniser and counter.
// clean_state moves to a new level only after the synchronised input has held that level for STABLE_CYCLES clocks.
module debouncer_multi #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 300_000_000,
  parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] clean_state,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   clean_q, clean_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   sync_bit;

      // Oldest synchroniser stage is the only view of the raw input used downstream.
      assign sync_bit = sync_q[SYNC_STAGES-1];

      always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_bit == clean_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = sync_bit;
          cnt_d   = '0;
          rise_d  = sync_bit;
          fall_d  = ~sync_bit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
          cnt_q   <= '0;
          clean_q <= RESET_LEVEL;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          cnt_q   <= cnt_d;
          clean_q <= clean_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign clean_state[gi] = clean_q;
      assign rise_pulse[gi]  = rise_q;
      assign fall_pulse[gi]  = fall_q;
      assign pending[gi]     = sync_bit ^ clean_q;
    end
  endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: three instances (STABLE_CYCLES = 5, 300_000_000, 1) driven by one stimulus.
// A run-length model is compared with every output on each cycle, and directed checks use literal expectations.
module tb_debouncer_multi;
  localparam int CH   = 4;
  localparam int NCFG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] raw_in = 4'hF;

  logic [CH-1:0] d_clean [NCFG];
  logic [CH-1:0] d_rise  [NCFG];
  logic [CH-1:0] d_fall  [NCFG];
  logic [CH-1:0] d_pend  [NCFG];

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(5), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_small (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .clean_state(d_clean[0]), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]), .pending(d_pend[0])
  );

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(300_000_000), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_long (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .clean_state(d_clean[1]), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]), .pending(d_pend[1])
  );

  debouncer_multi #(.CHANNELS(CH), .STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_one (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .clean_state(d_clean[2]), .rise_pulse(d_rise[2]), .fall_pulse(d_fall[2]), .pending(d_pend[2])
  );

  function automatic int stable_of(input int k);
    case (k)
      0:       return 5;
      1:       return 300_000_000;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Model: sync is raw_in seen two edges ago; clean flips once the mismatch run reaches STABLE_CYCLES.
  logic [CH-1:0] m_s1    [NCFG];
  logic [CH-1:0] m_s2    [NCFG];
  logic [CH-1:0] m_clean [NCFG];
  logic [CH-1:0] m_rise  [NCFG];
  logic [CH-1:0] m_fall  [NCFG];
  int            m_run   [NCFG][CH];
  bit            model_live = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < NCFG; k++) begin
        if (rst) begin
          m_s1[k] = '0; m_s2[k] = '0; m_clean[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
          for (int c = 0; c < CH; c++) m_run[k][c] = 0;
        end else begin
          m_rise[k] = '0;
          m_fall[k] = '0;
          for (int c = 0; c < CH; c++) begin
            if (m_s2[k][c] != m_clean[k][c]) begin
              m_run[k][c] = m_run[k][c] + 1;
              if (m_run[k][c] == stable_of(k)) begin
                m_clean[k][c] = m_s2[k][c];
                m_rise[k][c]  = m_s2[k][c];
                m_fall[k][c]  = ~m_s2[k][c];
                m_run[k][c]   = 0;
              end
            end else begin
              m_run[k][c] = 0;
            end
          end
          m_s2[k] = m_s1[k];
          m_s1[k] = raw_in;
        end
      end
      model_live = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        for (int k = 0; k < NCFG; k++) begin
          chk($sformatf("cfg%0d clean_state", k), d_clean[k], m_clean[k]);
          chk($sformatf("cfg%0d rise_pulse", k),  d_rise[k],  m_rise[k]);
          chk($sformatf("cfg%0d fall_pulse", k),  d_fall[k],  m_fall[k]);
          chk($sformatf("cfg%0d pending", k),     d_pend[k],  m_s2[k] ^ m_clean[k]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held 3 cycles with all inputs high
    $display("[TB] reset with raw_in=F");
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst clean", d_clean[0], 4'h0);
      chk("rst rise",  d_rise[0],  4'h0);
      chk("rst pend",  d_pend[0],  4'h0);
    end
    rst = 1'b0;
    step(6);
    chk("post-rst clean@6", d_clean[0], 4'h0);
    step(1);
    chk("post-rst clean@7", d_clean[0], 4'hF);
    chk("post-rst rise@7",  d_rise[0],  4'hF);
    step(1);
    chk("post-rst rise@8",  d_rise[0],  4'h0);
    chk("post-rst clean@8", d_clean[0], 4'hF);

    $display("[TB] all channels released");
    raw_in = 4'h0;
    step(10);
    chk("released clean", d_clean[0], 4'h0);

    $display("[TB] clean press ch0");
    raw_in = 4'b0001;
    step(1);
    chk("press pend@1",  d_pend[0],  4'b0000);
    step(1);
    chk("press pend@2",  d_pend[0],  4'b0001);
    step(4);
    chk("press clean@6", d_clean[0], 4'b0000);
    step(1);
    chk("press clean@7", d_clean[0], 4'b0001);
    chk("press rise@7",  d_rise[0],  4'b0001);
    step(1);
    chk("press rise@8",  d_rise[0],  4'b0000);
    chk("press pend@8",  d_pend[0],  4'b0000);

    $display("[TB] glitch on ch1");
    raw_in = 4'b0011; step(4);
    raw_in = 4'b0001; step(1);
    raw_in = 4'b0011; step(4);
    raw_in = 4'b0001; step(10);
    chk("glitch clean", d_clean[0], 4'b0001);
    chk("glitch pend",  d_pend[0],  4'b0000);

    $display("[TB] simultaneous release ch2/ch3");
    raw_in = 4'b1101; step(10);
    chk("sim set clean", d_clean[0], 4'b1101);
    raw_in = 4'b0001;
    step(6);
    chk("sim fall@6",  d_fall[0],  4'b0000);
    step(1);
    chk("sim fall@7",  d_fall[0],  4'b1100);
    chk("sim clean@7", d_clean[0], 4'b0001);
    step(1);
    chk("sim fall@8",  d_fall[0],  4'b0000);

    $display("[TB] reset mid-count on ch0");
    raw_in = 4'b0000; step(10);
    chk("mid idle clean", d_clean[0], 4'b0000);
    raw_in = 4'b0001;
    step(5);
    chk("mid pend@5", d_pend[0], 4'b0001);
    rst = 1'b1;
    step(1);
    chk("mid rst pend",  d_pend[0],  4'b0000);
    chk("mid rst clean", d_clean[0], 4'b0000);
    rst = 1'b0;
    step(6);
    chk("mid clean@6", d_clean[0], 4'b0000);
    chk("mid rise@6",  d_rise[0],  4'b0000);
    step(1);
    chk("mid clean@7", d_clean[0], 4'b0001);
    chk("mid rise@7",  d_rise[0],  4'b0001);
    step(2);

    $display("[TB] long-count instance still counting");
    chk("long clean", d_clean[1], 4'b0000);
    chk("long pend",  d_pend[1],  4'b0001);
    chk("one clean",  d_clean[2], 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
